// File: rtl/rcv_fifo_if.sv
// rcv_fifo_if: bundles the write strobe/data, pop strobe, FWFT head data and
// status flags that connect the receive FIFO to the serial receiver and the
// host bus.
//   wr, wr_data : byte capture strobe and data (from the receiver)
//   rd          : pop strobe (from the host)
//   rd_data     : head byte, valid while avail=1
//   avail, half : non-empty and at-least-half-full flags
//   count       : stored bytes, 0..2**DEPTH_LOG2
//   ovr, ovr_clr: sticky overrun flag and its clear
// The slave modport is the FIFO itself; master is the side that drives it.
interface rcv_fifo_if #(
  parameter int DEPTH_LOG2 = 4
) ();
  logic                  wr;
  logic [7:0]            wr_data;
  logic                  rd;
  logic [7:0]            rd_data;
  logic                  avail;
  logic                  half;
  logic [DEPTH_LOG2:0]   count;
  logic                  ovr;
  logic                  ovr_clr;

  modport master (
    output wr, wr_data, rd, ovr_clr,
    input  rd_data, avail, half, count, ovr
  );

  modport slave (
    input  wr, wr_data, rd, ovr_clr,
    output rd_data, avail, half, count, ovr
  );
endinterface

// File: rtl/rcv_fifo.sv
// rcv_fifo: first-word-fall-through receive buffer, 2**DEPTH_LOG2 x 8 bits.
// Captures a byte on each wr pulse, presents the oldest byte on rd_data, pops
// on rd, and reports fill level, half-full and a sticky overrun flag.
// Ports:
//   clk : system clock, all state changes on the rising edge
//   rst : synchronous active-high reset (pointers, count, ovr)
//   bus : rcv_fifo_if slave modport (wr/wr_data/rd/ovr_clr in;
//         rd_data/avail/half/count/ovr out)
module rcv_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  rcv_fifo_if.slave  bus
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_HALF  = (DEPTH_LOG2 + 1)'(DEPTH / 2);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = '0;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = '0;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [7:0]            mem_r [DEPTH];
  logic [DEPTH_LOG2-1:0] wp_r;
  logic [DEPTH_LOG2-1:0] rp_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic                  ovr_r;

  logic full_s;
  logic empty_s;
  logic wr_acc_s;
  logic wr_rej_s;
  logic rd_eff_s;

  assign full_s   = (count_r == CNT_FULL);
  assign empty_s  = (count_r == CNT_ZERO);
  // A full FIFO still accepts a write when the head is popped in the same cycle.
  assign wr_acc_s = bus.wr && (!full_s || bus.rd);
  assign wr_rej_s = bus.wr && full_s && !bus.rd;
  // A pop on an empty FIFO is ignored even if a byte arrives in that cycle.
  assign rd_eff_s = bus.rd && !empty_s;

  // Storage array: written on accepted writes only, never reset.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc_s) begin
      mem_r[wp_r] <= bus.wr_data;
    end
  end

  // Pointers, fill count and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_r    <= PTR_ZERO;
      rp_r    <= PTR_ZERO;
      count_r <= CNT_ZERO;
      ovr_r   <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wp_r <= wp_r + PTR_ONE;
      end
      if (rd_eff_s) begin
        rp_r <= rp_r + PTR_ONE;
      end
      case ({wr_acc_s, rd_eff_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      // Setting beats clearing when both happen together.
      if (wr_rej_s) begin
        ovr_r <= 1'b1;
      end else if (bus.ovr_clr) begin
        ovr_r <= 1'b0;
      end
    end
  end

  assign bus.rd_data = mem_r[rp_r];
  assign bus.avail   = !empty_s;
  assign bus.half    = (count_r >= CNT_HALF);
  assign bus.count   = count_r;
  assign bus.ovr     = ovr_r;

endmodule

// File: tb/tb_rcv_fifo.sv
// tb_rcv_fifo: directed self-checking bench for rcv_fifo (depth 16).
module tb_rcv_fifo;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  rcv_fifo_if #(.DEPTH_LOG2(4)) bus ();

  rcv_fifo #(.DEPTH_LOG2(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; strobes are single-cycle so they drop after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    rst         = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.ovr_clr = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr      = 1'b1;
    bus.wr_data = d;
    tick();
  endtask

  task automatic pop();
    bus.rd = 1'b1;
    tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    bus.wr      = 1'b0;
    bus.wr_data = 8'h00;
    bus.rd      = 1'b0;
    bus.ovr_clr = 1'b0;

    // 1: reset state, basic FWFT order
    rst = 1'b1;
    tick();
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_avail", 32'(bus.avail), 32'd0);
    chk("rst_half",  32'(bus.half),  32'd0);
    chk("rst_ovr",   32'(bus.ovr),   32'd0);
    push(8'h41);
    chk("t1_first_lat", 32'(bus.rd_data), 32'h41);
    chk("t1_first_av",  32'(bus.avail),   32'd1);
    tick();
    push(8'h42);
    tick();
    push(8'h43);
    tick();
    chk("t1_avail", 32'(bus.avail),   32'd1);
    chk("t1_count", 32'(bus.count),   32'd3);
    chk("t1_head",  32'(bus.rd_data), 32'h41);
    pop();
    chk("t1_pop1", 32'(bus.rd_data), 32'h42);
    pop();
    chk("t1_pop2", 32'(bus.rd_data), 32'h43);
    pop();
    chk("t1_empty_av", 32'(bus.avail), 32'd0);
    chk("t1_empty_ct", 32'(bus.count), 32'd0);

    // 2: half flag, full, overrun, dropped byte
    for (int i = 0; i < 7; i++) push(8'(8'h10 + i));
    chk("t2_half7", 32'(bus.half),  32'd0);
    chk("t2_cnt7",  32'(bus.count), 32'd7);
    push(8'h17);
    chk("t2_half8", 32'(bus.half),  32'd1);
    for (int i = 8; i < 16; i++) push(8'(8'h10 + i));
    chk("t2_full_ct",  32'(bus.count), 32'd16);
    chk("t2_full_ovr", 32'(bus.ovr),   32'd0);
    push(8'h99);
    chk("t2_rej_ct",  32'(bus.count), 32'd16);
    chk("t2_rej_ovr", 32'(bus.ovr),   32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t2_drain", 32'(bus.rd_data), 32'(8'(8'h10 + i)));
      pop();
    end
    chk("t2_drained", 32'(bus.count), 32'd0);
    chk("t2_ovr_sticky", 32'(bus.ovr), 32'd1);
    pop();
    chk("t2_pop_empty", 32'(bus.count), 32'd0);
    bus.ovr_clr = 1'b1;
    tick();
    chk("t2_ovr_clr", 32'(bus.ovr), 32'd0);

    // 3: simultaneous read and write while full
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    bus.wr      = 1'b1;
    bus.wr_data = 8'h5A;
    bus.rd      = 1'b1;
    tick();
    chk("t3_rw_ct",   32'(bus.count),   32'd16);
    chk("t3_rw_ovr",  32'(bus.ovr),     32'd0);
    chk("t3_rw_head", 32'(bus.rd_data), 32'h21);
    for (int i = 0; i < 16; i++) begin
      chk("t3_drain", 32'(bus.rd_data), (i < 15) ? 32'(8'(8'h21 + i)) : 32'h5A);
      pop();
    end
    chk("t3_drained", 32'(bus.count), 32'd0);

    // 4: simultaneous read and write while empty
    bus.wr      = 1'b1;
    bus.wr_data = 8'h33;
    bus.rd      = 1'b1;
    tick();
    chk("t4_count", 32'(bus.count),   32'd1);
    chk("t4_data",  32'(bus.rd_data), 32'h33);
    chk("t4_avail", 32'(bus.avail),   32'd1);
    pop();
    chk("t4_empty", 32'(bus.count), 32'd0);

    // 5: overrun set beats clear
    for (int i = 0; i < 16; i++) push(8'(8'h60 + i));
    push(8'hEE);
    chk("t5_ovr_set", 32'(bus.ovr), 32'd1);
    bus.wr      = 1'b1;
    bus.wr_data = 8'hEF;
    bus.ovr_clr = 1'b1;
    tick();
    chk("t5_set_wins", 32'(bus.ovr),   32'd1);
    chk("t5_set_ct",   32'(bus.count), 32'd16);
    bus.ovr_clr = 1'b1;
    tick();
    chk("t5_clr", 32'(bus.ovr), 32'd0);
    chk("t5_head", 32'(bus.rd_data), 32'h60);
    for (int i = 0; i < 16; i++) pop();
    chk("t5_drained", 32'(bus.count), 32'd0);

    // 6: order across pointer wrap, then mid-stream reset
    push(8'hA0);
    push(8'hA1);
    for (int i = 0; i < 20; i++) begin
      push(8'(8'hA2 + i));
      chk("t6_wrap", 32'(bus.rd_data), 32'(8'(8'hA0 + i)));
      pop();
    end
    chk("t6_count", 32'(bus.count),   32'd2);
    chk("t6_head",  32'(bus.rd_data), 32'hB4);
    for (int i = 0; i < 3; i++) push(8'(8'hC0 + i));
    chk("t6_cnt5", 32'(bus.count), 32'd5);
    rst = 1'b1;
    tick();
    chk("t6_rst_ct",  32'(bus.count), 32'd0);
    chk("t6_rst_av",  32'(bus.avail), 32'd0);
    chk("t6_rst_ovr", 32'(bus.ovr),   32'd0);
    push(8'h11);
    chk("t6_after_rst", 32'(bus.rd_data), 32'h11);
    chk("t6_after_ct",  32'(bus.count),   32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
